header_loader: RTL and testbench
================================

HEADER_LOADER -- requirements
Module: header_loader

Interface
REQ-001 The block SHALL have parameter ADDRESSWIDTH, default 28, meaning the width of the read-master byte address and length.
REQ-002 The block SHALL have parameter DATAWIDTH, default 32, meaning the width of a read-buffer word and of a core word.
REQ-003 The block SHALL have parameter HDR_WORDS, default 20, meaning the number of words per block header (80 bytes).
REQ-004 The block SHALL have parameter START_CODE, default 4'h1, meaning the start_out value that commands the core to hash.
REQ-005 The block SHALL have parameter TIMEOUT, default 65535, meaning the maximum cycles to wait for read_control_done.
REQ-006 The block SHALL have parameter SWAP_BYTES, default 1, meaning byte-reverse each word before forwarding it to the core.
REQ-007 Port clk, input, 1 bit: the single clock; all state is on the rising edge.
REQ-008 Port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-009 Port job_req, input, 1 bit: single-cycle request to load one header.
REQ-010 Port job_base, input, ADDRESSWIDTH bits: header byte address, sampled on an accepted job_req.
REQ-011 Port busy, output, 1 bit: high in every state except IDLE.
REQ-012 Port job_done, output, 1 bit: single-cycle pulse marking a completed load.
REQ-013 Port job_err, output, 1 bit: sticky timeout flag, cleared by the next accepted job_req.
REQ-014 Port read_control_fixed_location, output, 1 bit: constant 0.
REQ-015 Port read_control_read_base, output, ADDRESSWIDTH bits: the latched job_base.
REQ-016 Port read_control_read_length, output, ADDRESSWIDTH bits: constant HDR_WORDS*4.
REQ-017 Port read_control_go, output, 1 bit: single-cycle pulse that starts the read master.
REQ-018 Port read_control_done, input, 1 bit: the read master has finished the transfer.
REQ-019 Port read_user_read_buffer, output, 1 bit: pops one word from the show-ahead FIFO.
REQ-020 Port read_user_buffer_output_data, input, DATAWIDTH bits: the FIFO head word.
REQ-021 Port read_user_data_available, input, 1 bit: the FIFO is non-empty.
REQ-022 Port shift_out_enable, output, 1 bit: core_out is valid this cycle.
REQ-023 Port core_out, output, DATAWIDTH bits: the header word presented to the core.
REQ-024 Port start_out, output, 4 bits: core command; 0 when idle, START_CODE for one cycle.

Function
REQ-025 The FSM SHALL have the states IDLE, ISSUE, FETCH, DRAIN, START and FAIL.
REQ-026 IDLE SHALL accept job_req by latching job_base, clearing job_err and the word count, then going to ISSUE.
REQ-027 job_req outside IDLE SHALL be ignored.
REQ-028 ISSUE SHALL assert read_control_go for exactly 1 cycle and then go to FETCH.
REQ-029 FETCH: read_user_read_buffer SHALL equal read_user_data_available while the count is below HDR_WORDS (combinational), and 0 otherwise.
REQ-030 Each pop SHALL register its word (byte-swapped if SWAP_BYTES) into core_out and pulse shift_out_enable on the next cycle (1-cycle latency), and increment the count.
REQ-031 A word count beyond HDR_WORDS is impossible; excess FIFO data SHALL NOT be popped.
REQ-032 When HDR_WORDS words have been popped, FETCH SHALL go to DRAIN if read_control_done has not yet been seen, else to START.
REQ-033 read_control_done SHALL be latched whenever it is seen after ISSUE, including simultaneously with the final pop.
REQ-034 START SHALL drive start_out = START_CODE for 1 cycle, pulse job_done in the same cycle, then return to IDLE.
REQ-035 START SHALL occur at least 1 cycle after the last shift_out_enable.
REQ-036 A watchdog SHALL count cycles from entry to FETCH and SHALL reset on each pop.
REQ-037 When the watchdog reaches TIMEOUT in FETCH or DRAIN, the block SHALL set job_err, go to FAIL, and return from FAIL to IDLE after 1 cycle without asserting start_out.
REQ-038 All outputs SHALL be registered except read_user_read_buffer.

Reset
REQ-039 On n_rst low, the state SHALL be IDLE and busy, job_done, job_err, read_control_go, shift_out_enable, core_out, start_out, the latched base, the count, the watchdog and the done-latch SHALL all be 0.
REQ-040 Reset mid-load SHALL abandon the job with no further FIFO pops or core strobes; the FIFO is flushed by the system-level reset.

Structure
REQ-041 A shared package bitcoin_pkg SHALL hold the state enum, HDR_WORDS, START_CODE and the byte-swap function.
REQ-042 The block SHALL use no sub-module; the watchdog is an inline counter.

Verification
REQ-043 Nominal: job_base=0x0000100, FIFO supplies words 0x00000001..0x00000014 back-to-back, then done -> go pulses once, base=0x100, length=80; 20 strobes with core_out=0x01000000..0x14000000; start_out=1 and job_done each 1 cycle.
REQ-044 Stalled FIFO: data_available toggling every 3 cycles -> pops only when available, still 20 strobes, order preserved, single start.
REQ-045 Late done: all words delivered, done arrives 50 cycles later -> DRAIN is held 50 cycles, then START; done together with the last pop -> START with no DRAIN.
REQ-046 Timeout: TIMEOUT=100, only 5 words delivered -> job_err=1 after 100 idle cycles, no start_out; the next job_req clears job_err.
REQ-047 Reset: n_rst asserted after word 10 -> all outputs 0 immediately; the next job completes normally; a job_req while busy has no effect.

Source files
------------

// File: rtl/bitcoin_pkg.sv
`default_nettype none
// ============================================================================
// Package : bitcoin_pkg
// Shared loader state encoding, header geometry, core command and byte swap.
// Rev     : 1.0
// ============================================================================
package bitcoin_pkg;

  localparam int         HDR_WORDS  = 20;
  localparam logic [3:0] START_CODE = 4'h1;
  localparam int         MAX_DW     = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    FETCH = 3'd2,
    DRAIN = 3'd3,
    START = 3'd4,
    FAIL  = 3'd5
  } state_t;

  // Reverses the lowest nbytes bytes of d; bytes above nbytes come back as zero.
  function automatic logic [MAX_DW-1:0] byte_swap(input logic [MAX_DW-1:0] d,
                                                  input int                nbytes);
    logic [MAX_DW-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DW / 8; i++) begin
      if (i < nbytes) begin
        r[8*i +: 8] = d[8*(nbytes-1-i) +: 8];
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/header_loader.sv
`default_nettype none
// ============================================================================
// Module : header_loader
// Fetches one block header through the read master and streams it to the core.
// Rev    : 1.0
// ============================================================================
module header_loader #(
  parameter int         ADDRESSWIDTH = 28,
  parameter int         DATAWIDTH    = 32,
  parameter int         HDR_WORDS    = bitcoin_pkg::HDR_WORDS,
  parameter logic [3:0] START_CODE   = bitcoin_pkg::START_CODE,
  parameter int         TIMEOUT      = 65535,
  parameter bit         SWAP_BYTES   = 1'b1
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    job_req,
  input  logic [ADDRESSWIDTH-1:0] job_base,
  output logic                    busy,
  output logic                    job_done,
  output logic                    job_err,
  output logic                    read_control_fixed_location,
  output logic [ADDRESSWIDTH-1:0] read_control_read_base,
  output logic [ADDRESSWIDTH-1:0] read_control_read_length,
  output logic                    read_control_go,
  input  logic                    read_control_done,
  output logic                    read_user_read_buffer,
  input  logic [DATAWIDTH-1:0]    read_user_buffer_output_data,
  input  logic                    read_user_data_available,
  output logic                    shift_out_enable,
  output logic [DATAWIDTH-1:0]    core_out,
  output logic [3:0]              start_out
);
  import bitcoin_pkg::*;

  localparam int                      CW       = $clog2(HDR_WORDS + 1);
  localparam logic [CW-1:0]           LAST_CNT = CW'(HDR_WORDS);
  localparam int                      WW       = (TIMEOUT < 2) ? 2 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0]           WD_MAX   = WW'(TIMEOUT);
  localparam logic [ADDRESSWIDTH-1:0] HDR_LEN  = ADDRESSWIDTH'(HDR_WORDS * 4);

  state_t                  state;
  state_t                  next_state;
  logic [CW-1:0]           count;
  logic [WW-1:0]           wd;
  logic                    done_seen;
  logic [ADDRESSWIDTH-1:0] base;
  logic [DATAWIDTH-1:0]    word_in;
  logic                    accept;
  logic                    pop;
  logic                    full;
  logic                    done_any;
  logic                    wd_expired;

  assign accept     = (state == IDLE) && job_req;
  assign full       = (count == LAST_CNT);
  assign pop        = (state == FETCH) && !full && read_user_data_available;
  assign done_any   = done_seen || read_control_done;
  assign wd_expired = (wd == WD_MAX);

  assign read_user_read_buffer       = pop;
  assign read_control_fixed_location = 1'b0;
  assign read_control_read_length    = HDR_LEN;
  assign read_control_read_base      = base;

  generate
    if (SWAP_BYTES) begin : g_swap
      logic [MAX_DW-1:0] swapped;
      assign swapped = byte_swap(MAX_DW'(read_user_buffer_output_data), DATAWIDTH / 8);
      assign word_in = swapped[DATAWIDTH-1:0];
    end else begin : g_noswap
      assign word_in = read_user_buffer_output_data;
    end
  endgenerate

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Leaving FETCH waits for the cycle after the final pop so START never
  // coincides with the last core strobe.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (job_req) next_state = ISSUE;
      ISSUE:   next_state = FETCH;
      FETCH: begin
        if (full) begin
          next_state = done_any ? START : DRAIN;
        end else if (!pop && wd_expired) begin
          next_state = FAIL;
        end
      end
      DRAIN: begin
        if (done_any) begin
          next_state = START;
        end else if (wd_expired) begin
          next_state = FAIL;
        end
      end
      START:   next_state = IDLE;
      FAIL:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      base      <= '0;
      count     <= '0;
      wd        <= '0;
      done_seen <= 1'b0;
    end else begin
      if (accept) begin
        base <= job_base;
      end

      if (accept) begin
        count <= '0;
      end else if (pop) begin
        count <= count + CW'(1);
      end

      if (accept) begin
        done_seen <= 1'b0;
      end else if ((state == FETCH || state == DRAIN) && read_control_done) begin
        done_seen <= 1'b1;
      end

      // Saturates at the limit so an expired watchdog stays expired.
      if ((state == FETCH || state == DRAIN) && !pop) begin
        if (!wd_expired) begin
          wd <= wd + WW'(1);
        end
      end else begin
        wd <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy             <= 1'b0;
      job_done         <= 1'b0;
      job_err          <= 1'b0;
      read_control_go  <= 1'b0;
      shift_out_enable <= 1'b0;
      core_out         <= '0;
      start_out        <= 4'h0;
    end else begin
      busy             <= (next_state != IDLE);
      job_done         <= (next_state == START);
      read_control_go  <= (next_state == ISSUE);
      start_out        <= (next_state == START) ? START_CODE : 4'h0;
      shift_out_enable <= pop;
      if (pop) begin
        core_out <= word_in;
      end
      if (accept) begin
        job_err <= 1'b0;
      end else if (next_state == FAIL) begin
        job_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_header_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_header_loader
// Scoreboard bench for header_loader with a show-ahead FIFO and read master model.
// Rev    : 1.0
// ============================================================================
module tb_header_loader;
  localparam int AW = 28;
  localparam int DW = 32;
  localparam int HW = 20;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          job_req = 1'b0;
  logic [AW-1:0] job_base = '0;
  logic          busy, job_done, job_err;
  logic          read_control_fixed_location;
  logic [AW-1:0] read_control_read_base, read_control_read_length;
  logic          read_control_go;
  logic          read_control_done = 1'b0;
  logic          read_user_read_buffer;
  logic [DW-1:0] read_user_buffer_output_data = '0;
  logic          read_user_data_available = 1'b0;
  logic          shift_out_enable;
  logic [DW-1:0] core_out;
  logic [3:0]    start_out;

  header_loader #(
    .ADDRESSWIDTH(AW), .DATAWIDTH(DW), .HDR_WORDS(HW), .START_CODE(4'h1),
    .TIMEOUT(TO), .SWAP_BYTES(1'b1)
  ) dut (
    .clk(clk), .n_rst(n_rst), .job_req(job_req), .job_base(job_base),
    .busy(busy), .job_done(job_done), .job_err(job_err),
    .read_control_fixed_location(read_control_fixed_location),
    .read_control_read_base(read_control_read_base),
    .read_control_read_length(read_control_read_length),
    .read_control_go(read_control_go), .read_control_done(read_control_done),
    .read_user_read_buffer(read_user_read_buffer),
    .read_user_buffer_output_data(read_user_buffer_output_data),
    .read_user_data_available(read_user_data_available),
    .shift_out_enable(shift_out_enable), .core_out(core_out), .start_out(start_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] obs_q[$];
  bit  stall_mode = 1'b0;
  bit  gate_open  = 1'b1;
  int  gate_cnt   = 0;
  int  cyc = 0, n_go = 0, n_start = 0, n_done = 0, n_both = 0, n_overlap = 0, n_badpop = 0;
  int  last_sev_cyc = 0, start_cyc = 0;
  logic [3:0] last_start = 4'h0;

  function automatic logic [DW-1:0] bswap(input logic [DW-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // FIFO head leaves the queue on the edge where the DUT pops it.
  always @(posedge clk) begin
    if (read_user_read_buffer && fifo_q.size() > 0) void'(fifo_q.pop_front());
  end

  always @(negedge clk) begin
    cyc++;
    if (stall_mode) begin
      gate_cnt++;
      if (gate_cnt == 3) begin
        gate_cnt  = 0;
        gate_open = !gate_open;
      end
    end else begin
      gate_open = 1'b1;
    end
    read_user_buffer_output_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    read_user_data_available     = (fifo_q.size() > 0) && gate_open;
  end

  always @(negedge clk) begin
    #1;
    if (shift_out_enable) begin
      obs_q.push_back(core_out);
      last_sev_cyc = cyc;
    end
    if (start_out != 4'h0) begin
      n_start++;
      last_start = start_out;
      start_cyc  = cyc;
    end
    if (job_done) n_done++;
    if (job_done && start_out != 4'h0) n_both++;
    if (read_control_go) n_go++;
    if (shift_out_enable && start_out != 4'h0) n_overlap++;
    if (read_user_read_buffer && !read_user_data_available) n_badpop++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_stats();
    exp_q.delete(); obs_q.delete(); fifo_q.delete();
    n_go = 0; n_start = 0; n_done = 0; n_both = 0; n_overlap = 0; n_badpop = 0;
    last_start = 4'h0;
  endtask

  task automatic start_job(input logic [AW-1:0] base, input int nw);
    for (int i = 1; i <= nw; i++) begin
      fifo_q.push_back(DW'(i));
      if (i <= HW) exp_q.push_back(bswap(DW'(i)));
    end
    job_base = base;
    job_req  = 1'b1;
    tick();
    job_req  = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int bound, input string name);
    int k;
    k = 0;
    while (obs_q.size() < n && k < bound) begin
      tick();
      k++;
    end
    if (obs_q.size() < n) begin
      errors++;
      $display("FAIL %s_wait_strobes: got %0d strobes, expected %0d", name, obs_q.size(), n);
    end
  endtask

  task automatic pulse_done();
    read_control_done = 1'b1;
    tick();
    read_control_done = 1'b0;
  endtask

  task automatic wait_job_done(input int bound, input string name);
    int k;
    k = 0;
    while (n_done == 0 && k < bound) begin
      tick();
      k++;
    end
    tick();
    tick();
    checks++;
    if (n_done == 0) begin
      errors++;
      $display("FAIL %s_job_done_timeout: got no job_done within %0d cycles", name, bound);
    end
  endtask

  task automatic check_stream(input string name);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s_strobe_count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_word%0d: got %08h expected %08h", name, i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({busy, job_done, job_err, read_control_go, shift_out_enable, core_out, start_out,
         read_user_read_buffer, read_control_fixed_location} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b go=%b sev=%b core=%h start=%h rb=%b",
               busy, job_done, job_err, read_control_go, shift_out_enable, core_out, start_out,
               read_user_read_buffer);
    end
    n_rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || read_control_read_base !== '0) begin
      errors++;
      $display("FAIL reset_release: got busy=%b base=%h expected 0 0", busy, read_control_read_base);
    end
    checks++;
    if (read_control_read_length !== AW'(80)) begin
      errors++;
      $display("FAIL read_length: got %0d expected 80", read_control_read_length);
    end
  endtask

  task automatic test_nominal();
    clear_stats();
    start_job(AW'('h100), HW + 1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL nominal_busy: got %b expected 1", busy);
    end
    wait_strobes(HW, 200, "nominal");
    tick();
    pulse_done();
    wait_job_done(50, "nominal");
    check_stream("nominal");
    checks++;
    if (n_go !== 1) begin errors++; $display("FAIL nominal_go_count: got %0d expected 1", n_go); end
    checks++;
    if (read_control_read_base !== AW'('h100)) begin
      errors++;
      $display("FAIL nominal_base: got %h expected 100", read_control_read_base);
    end
    checks++;
    if (n_start !== 1 || last_start !== 4'h1) begin
      errors++;
      $display("FAIL nominal_start: got %0d cycles code %h expected 1 cycle code 1", n_start, last_start);
    end
    checks++;
    if (n_done !== 1 || n_both !== 1) begin
      errors++;
      $display("FAIL nominal_job_done: got %0d pulses %0d aligned expected 1 1", n_done, n_both);
    end
    checks++;
    if (n_overlap !== 0) begin
      errors++;
      $display("FAIL nominal_start_overlap: got %0d expected 0", n_overlap);
    end
    checks++;
    if (fifo_q.size() !== 1) begin
      errors++;
      $display("FAIL nominal_excess_pop: got %0d words left expected 1", fifo_q.size());
    end
    checks++;
    if (busy !== 1'b0 || job_err !== 1'b0) begin
      errors++;
      $display("FAIL nominal_idle: got busy=%b err=%b expected 0 0", busy, job_err);
    end
  endtask

  task automatic test_stall();
    clear_stats();
    stall_mode = 1'b1;
    gate_cnt   = 0;
    start_job(AW'('h200), HW);
    wait_strobes(HW, 600, "stall");
    pulse_done();
    wait_job_done(50, "stall");
    stall_mode = 1'b0;
    check_stream("stall");
    checks++;
    if (n_badpop !== 0) begin
      errors++;
      $display("FAIL stall_pop_unavailable: got %0d expected 0", n_badpop);
    end
    checks++;
    if (n_start !== 1) begin errors++; $display("FAIL stall_start: got %0d expected 1", n_start); end
  endtask

  task automatic test_late_done();
    int gap;
    clear_stats();
    start_job(AW'('h300), HW);
    wait_strobes(HW, 200, "late");
    for (int i = 0; i < 50; i++) tick();
    checks++;
    if (n_start !== 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL late_drain_hold: got start=%0d busy=%b expected 0 1", n_start, busy);
    end
    pulse_done();
    wait_job_done(20, "late");
    gap = start_cyc - last_sev_cyc;
    checks++;
    if (gap < 50 || gap > 55 || n_start !== 1) begin
      errors++;
      $display("FAIL late_start_gap: got gap %0d starts %0d expected gap 50..55 starts 1", gap, n_start);
    end
    check_stream("late");
  endtask

  task automatic test_done_with_last();
    int gap;
    int k;
    clear_stats();
    start_job(AW'('h400), HW);
    k = 0;
    while (!(fifo_q.size() == 1 && read_user_read_buffer) && k < 200) begin
      tick();
      k++;
    end
    pulse_done();
    wait_job_done(20, "withlast");
    gap = start_cyc - last_sev_cyc;
    checks++;
    if (gap !== 1 || n_start !== 1) begin
      errors++;
      $display("FAIL withlast_no_drain: got gap %0d starts %0d expected 1 1", gap, n_start);
    end
    check_stream("withlast");
  endtask

  task automatic test_timeout();
    int k;
    clear_stats();
    start_job(AW'('h800), 5);
    wait_strobes(5, 100, "timeout");
    k = 0;
    while (job_err !== 1'b1 && k < 300) begin
      tick();
      k++;
    end
    checks++;
    if (job_err !== 1'b1 || k < 95 || k > 105) begin
      errors++;
      $display("FAIL timeout_err_time: got err=%b after %0d cycles expected 1 after 95..105", job_err, k);
    end
    tick(); tick();
    checks++;
    if (n_start !== 0 || n_done !== 0 || busy !== 1'b0 || job_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_abort: got start=%0d done=%0d busy=%b err=%b expected 0 0 0 1",
               n_start, n_done, busy, job_err);
    end
    clear_stats();
    start_job(AW'('h900), HW);
    checks++;
    if (job_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err_clear: got %b expected 0", job_err);
    end
    wait_strobes(HW, 200, "after_timeout");
    pulse_done();
    wait_job_done(20, "after_timeout");
    check_stream("after_timeout");
  endtask

  task automatic test_reset_midload();
    int held;
    clear_stats();
    start_job(AW'('h500), HW);
    wait_strobes(10, 100, "midreset");
    n_rst = 1'b0;
    #1;
    checks++;
    if ({busy, job_done, job_err, read_control_go, shift_out_enable, core_out, start_out,
         read_user_read_buffer, read_control_read_base} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%b go=%b sev=%b core=%h start=%h rb=%b base=%h",
               busy, read_control_go, shift_out_enable, core_out, start_out,
               read_user_read_buffer, read_control_read_base);
    end
    fifo_q.delete();
    held = obs_q.size();
    tick(); tick(); tick();
    checks++;
    if (obs_q.size() !== held || n_start !== 0) begin
      errors++;
      $display("FAIL midreset_quiet: got %0d strobes %0d starts expected %0d 0", obs_q.size(), n_start, held);
    end
    n_rst = 1'b1;
    tick();
    clear_stats();
    start_job(AW'('h600), HW);
    tick(); tick();
    job_base = AW'('h7777);
    job_req  = 1'b1;
    tick();
    job_req  = 1'b0;
    wait_strobes(HW, 200, "postreset");
    pulse_done();
    wait_job_done(20, "postreset");
    check_stream("postreset");
    checks++;
    if (read_control_read_base !== AW'('h600) || n_go !== 1 || n_start !== 1) begin
      errors++;
      $display("FAIL busy_req_ignored: got base=%h go=%0d start=%0d expected 600 1 1",
               read_control_read_base, n_go, n_start);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_late_done();
    test_done_with_last();
    test_timeout();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
